// File: rtl/aes_pkg.sv
// Shared types, widths and the GF(2^8) S-box function for the SubBytes scheduler.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sched_state_t;
    typedef enum logic {STATE, KEY} grant_t;

    localparam int WORD_W  = 32;
    localparam int LANES   = 4;
    localparam int STATE_W = 128;

    localparam logic [7:0] INV_EXP = 8'hFE;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine transform.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 0; i < 8; i++) begin
            if (INV_EXP[i]) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/subbytes_scheduler_sbox_word.sv
// Combinational 32-bit SubWord: four byte-wide S-box lanes.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = sbox_byte(din);
endmodule

module sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox u_sbox (
            .din  (din[g*8 +: 8]),
            .dout (dout[g*8 +: 8])
        );
    end
endmodule

// File: rtl/subbytes_scheduler.sv
// Time-shares one 4-lane S-box bank between 128-bit SubBytes and key SubWord.
// Build option SUBBYTES_SCHED_PERF_EN adds the stall_cnt performance counter port.
module subbytes_scheduler
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [STATE_W-1:0] st_in,
    output logic               st_out_valid,
    input  logic               st_out_ready,
    output logic [STATE_W-1:0] st_out,
    input  logic               kw_valid,
    output logic               kw_ready,
    input  logic [WORD_W-1:0]  kw_in,
    output logic               kw_out_valid,
    output logic [WORD_W-1:0]  kw_out
`ifdef SUBBYTES_SCHED_PERF_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    sched_state_t       state_q, state_d;
    grant_t             last_grant_q, last_grant_d;
    logic [1:0]         idx_q, idx_d;
    logic [STATE_W-1:0] buf_q, buf_d;
    logic [STATE_W-1:0] st_out_q, st_out_d;
    logic [WORD_W-1:0]  kw_out_q, kw_out_d;
    logic               kw_out_valid_q, kw_out_valid_d;

    logic               key_gnt_busy;
    logic               kw_acc;
    logic [WORD_W-1:0]  sbox_in;
    logic [WORD_W-1:0]  sbox_out;

    // Word idx lives at bit offset (3-idx)*32, i.e. {~idx, 5'b0}.
    assign key_gnt_busy = (state_q == BUSY) && kw_valid && (last_grant_q == STATE);
    assign kw_ready     = (state_q != BUSY) || key_gnt_busy;
    assign kw_acc       = kw_valid && kw_ready;
    assign sbox_in      = kw_acc ? kw_in : buf_q[{~idx_q, 5'd0} +: WORD_W];

    sbox_word u_sbox_word (
        .din  (sbox_in),
        .dout (sbox_out)
    );

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        idx_d          = idx_q;
        buf_d          = buf_q;
        st_out_d       = st_out_q;
        kw_out_d       = kw_out_q;
        kw_out_valid_d = kw_acc;
        if (kw_acc) kw_out_d = sbox_out;
        case (state_q)
            IDLE: begin
                if (st_valid) begin
                    buf_d   = st_in;
                    idx_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (key_gnt_busy) begin
                    last_grant_d = KEY;
                end else begin
                    st_out_d[{~idx_q, 5'd0} +: WORD_W] = sbox_out;
                    last_grant_d = STATE;
                    if (idx_q == 2'd3) state_d = DONE;
                    else               idx_d   = idx_q + 2'd1;
                end
            end
            DONE: begin
                if (st_out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= STATE;
            idx_q          <= 2'd0;
            buf_q          <= '0;
            st_out_q       <= '0;
            kw_out_q       <= '0;
            kw_out_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            idx_q          <= idx_d;
            buf_q          <= buf_d;
            st_out_q       <= st_out_d;
            kw_out_q       <= kw_out_d;
            kw_out_valid_q <= kw_out_valid_d;
        end
    end

    assign st_ready     = (state_q == IDLE);
    assign st_out_valid = (state_q == DONE);
    assign st_out       = st_out_q;
    assign kw_out       = kw_out_q;
    assign kw_out_valid = kw_out_valid_q;

`ifdef SUBBYTES_SCHED_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (key_gnt_busy && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= 16'd0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_subbytes_scheduler.sv
// Self-checking bench for subbytes_scheduler against a table-driven AES SubBytes model.
module tb_subbytes_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st_valid, st_ready, st_out_valid, st_out_ready;
    logic [127:0] st_in, st_out;
    logic         kw_valid, kw_ready, kw_out_valid;
    logic [31:0]  kw_in, kw_out;
`ifdef SUBBYTES_SCHED_PERF_EN
    logic [15:0]  stall_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] tbl [256];

    always #5 clk = ~clk;

    subbytes_scheduler dut (
`ifdef SUBBYTES_SCHED_PERF_EN
        .stall_cnt    (stall_cnt),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_in        (st_in),
        .st_out_valid (st_out_valid),
        .st_out_ready (st_out_ready),
        .st_out       (st_out),
        .kw_valid     (kw_valid),
        .kw_ready     (kw_ready),
        .kw_in        (kw_in),
        .kw_out_valid (kw_out_valid),
        .kw_out       (kw_out)
    );

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = (v << n) | (v >> (8 - n));
        return r;
    endfunction

    // Generator walk over GF(2^8): p runs through powers of 3, q through powers of its inverse.
    task automatic build_table();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            tbl[p] = x ^ 8'h63;
        end while (p != 8'h01);
        tbl[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tbl[w[31:24]], tbl[w[23:16]], tbl[w[15:8]], tbl[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = tbl[s[i*8 +: 8]];
        return r;
    endfunction

    // Drives one state operation and tracks the expected grant pattern:
    // in BUSY a pending key wins unless the previous BUSY grant was already the key.
    task automatic run_op(input logic [127:0] s, input int mode, input logic sim_kw,
                          input logic [31:0] sim_word, output int lat, output int keys,
                          output int kerr);
        int mstate, words;
        logic prev_key, exp_kr, acc;
        logic [31:0] word;
        lat = 0; keys = 0; kerr = 0; mstate = 0; words = 0; prev_key = 1'b0;
        @(negedge clk);
        st_valid = 1'b1; st_in = s; kw_valid = sim_kw; kw_in = sim_word;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            #1;
            exp_kr = (mstate == 1) ? (kw_valid && !prev_key) : 1'b1;
            if (kw_ready !== exp_kr) kerr++;
            acc  = kw_valid && exp_kr;
            word = kw_in;
            if (mstate == 0) begin
                mstate = 1;
            end else if (mstate == 1) begin
                if (acc) begin
                    prev_key = 1'b1; keys++;
                end else begin
                    prev_key = 1'b0; words++;
                    if (words == 4) mstate = 2;
                end
            end
            @(posedge clk); #1;
            st_valid = 1'b0;
            if (kw_out_valid !== acc) kerr++;
            if (acc && kw_out !== sub_word(word)) kerr++;
            if (st_out_valid === 1'b1) lat = n;
            @(negedge clk);
            if (acc) kw_valid = 1'b0;
            if (mstate == 1 && lat == 0) begin
                if (mode == 1) begin
                    if (!kw_valid) begin kw_valid = 1'b1; kw_in = $urandom; end
                end else if (mode == 2) begin
                    if (!kw_valid) begin kw_valid = 1'($urandom_range(0, 1)); kw_in = $urandom; end
                end
            end else begin
                kw_valid = 1'b0;
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk); st_out_ready = 1'b1;
        @(posedge clk); #1;
        st_out_ready = 1'b0;
    endtask

    localparam logic [127:0] VEC_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] VEC_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    task automatic test_reset();
        rst_n = 1'b0; st_valid = 1'b0; st_in = '0; st_out_ready = 1'b0;
        kw_valid = 1'b0; kw_in = '0;
        #23;
        total_cnt++; if (st_ready !== 1'b1) $display("FAIL reset_st_ready got %b want 1", st_ready); else pass_cnt++;
        total_cnt++; if (st_out_valid !== 1'b0) $display("FAIL reset_st_out_valid got %b want 0", st_out_valid); else pass_cnt++;
        total_cnt++; if (st_out !== '0) $display("FAIL reset_st_out got %h want 0", st_out); else pass_cnt++;
        total_cnt++; if (kw_out_valid !== 1'b0) $display("FAIL reset_kw_out_valid got %b want 0", kw_out_valid); else pass_cnt++;
        total_cnt++; if (kw_out !== '0) $display("FAIL reset_kw_out got %h want 0", kw_out); else pass_cnt++;
`ifdef SUBBYTES_SCHED_PERF_EN
        total_cnt++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else pass_cnt++;
`endif
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vector();
        int lat, keys, kerr;
        run_op(VEC_IN, 0, 1'b0, 32'h0, lat, keys, kerr);
        total_cnt++; if (lat !== 5) $display("FAIL vec_latency got %0d want 5", lat); else pass_cnt++;
        total_cnt++; if (st_out !== VEC_OUT) $display("FAIL vec_st_out got %h want %h", st_out, VEC_OUT); else pass_cnt++;
        total_cnt++; if (st_ready !== 1'b0) $display("FAIL vec_done_st_ready got %b want 0", st_ready); else pass_cnt++;
        release_out();
        total_cnt++; if (st_out_valid !== 1'b0) $display("FAIL vec_valid_drop got %b want 0", st_out_valid); else pass_cnt++;
        total_cnt++; if (st_ready !== 1'b1) $display("FAIL vec_idle_st_ready got %b want 1", st_ready); else pass_cnt++;
    endtask

    task automatic test_key_idle();
        @(negedge clk); kw_valid = 1'b1; kw_in = 32'hcf4f3c09;
        #1;
        total_cnt++; if (kw_ready !== 1'b1) $display("FAIL key_idle_ready got %b want 1", kw_ready); else pass_cnt++;
        @(posedge clk); #1;
        kw_valid = 1'b0;
        total_cnt++; if (kw_out_valid !== 1'b1) $display("FAIL key_idle_valid got %b want 1", kw_out_valid); else pass_cnt++;
        total_cnt++; if (kw_out !== 32'h8a84eb01) $display("FAIL key_idle_out got %h want 8a84eb01", kw_out); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (kw_out_valid !== 1'b0) $display("FAIL key_idle_pulse got %b want 0", kw_out_valid); else pass_cnt++;
        total_cnt++; if (kw_out !== 32'h8a84eb01) $display("FAIL key_idle_hold got %h want 8a84eb01", kw_out); else pass_cnt++;
    endtask

    task automatic test_contention();
        int lat, keys, kerr;
`ifdef SUBBYTES_SCHED_PERF_EN
        logic [15:0] base;
        base = stall_cnt;
`endif
        run_op(VEC_IN, 1, 1'b0, 32'h0, lat, keys, kerr);
        total_cnt++; if (lat !== 9) $display("FAIL cont_latency got %0d want 9", lat); else pass_cnt++;
        total_cnt++; if (keys !== 4) $display("FAIL cont_key_grants got %0d want 4", keys); else pass_cnt++;
        total_cnt++; if (kerr !== 0) $display("FAIL cont_key_path errors %0d want 0", kerr); else pass_cnt++;
        total_cnt++; if (st_out !== VEC_OUT) $display("FAIL cont_st_out got %h want %h", st_out, VEC_OUT); else pass_cnt++;
`ifdef SUBBYTES_SCHED_PERF_EN
        total_cnt++; if (stall_cnt !== base + 16'd4) $display("FAIL cont_stall_cnt got %0d want %0d", stall_cnt, base + 16'd4); else pass_cnt++;
`endif
        release_out();
    endtask

    task automatic test_simultaneous();
        int lat, keys, kerr;
        run_op(VEC_IN, 0, 1'b1, 32'h00000000, lat, keys, kerr);
        total_cnt++; if (kerr !== 0) $display("FAIL simul_key_path errors %0d want 0", kerr); else pass_cnt++;
        total_cnt++; if (kw_out !== 32'h63636363) $display("FAIL simul_kw_out got %h want 63636363", kw_out); else pass_cnt++;
        total_cnt++; if (lat !== 5) $display("FAIL simul_latency got %0d want 5", lat); else pass_cnt++;
        total_cnt++; if (st_out !== VEC_OUT) $display("FAIL simul_st_out got %h want %h", st_out, VEC_OUT); else pass_cnt++;
        release_out();
    endtask

    task automatic test_done_hold();
        int lat, keys, kerr, bad;
        logic [127:0] s, exp;
        logic [31:0] w;
        s = {$urandom, $urandom, $urandom, $urandom};
        exp = sub_state(s);
        bad = 0;
        run_op(s, 0, 1'b0, 32'h0, lat, keys, kerr);
        total_cnt++; if (lat !== 5) $display("FAIL hold_latency got %0d want 5", lat); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) begin kw_valid = 1'b1; w = $urandom; kw_in = w; end
            #1;
            if (i == 4 && kw_ready !== 1'b1) bad++;
            @(posedge clk); #1;
            kw_valid = 1'b0;
            if (st_out_valid !== 1'b1 || st_out !== exp || st_ready !== 1'b0) bad++;
            if (kw_out_valid !== (i == 4)) bad++;
            if (i == 4 && kw_out !== sub_word(w)) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL hold_stable errors %0d want 0", bad); else pass_cnt++;
        release_out();
        total_cnt++; if (st_out_valid !== 1'b0) $display("FAIL hold_release got %b want 0", st_out_valid); else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, keys, kerr;
        logic [127:0] s;
        for (int k = 0; k < 6; k++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            run_op(s, 2, 1'($urandom_range(0, 1)), $urandom, lat, keys, kerr);
            total_cnt++; if (st_out !== sub_state(s)) $display("FAIL rand%0d_st_out got %h want %h", k, st_out, sub_state(s)); else pass_cnt++;
            total_cnt++; if (lat !== 5 + keys) $display("FAIL rand%0d_latency got %0d want %0d", k, lat, 5 + keys); else pass_cnt++;
            total_cnt++; if (kerr !== 0) $display("FAIL rand%0d_key_path errors %0d want 0", k, kerr); else pass_cnt++;
            release_out();
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        @(negedge clk); st_valid = 1'b1; st_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1; st_valid = 1'b0;
        @(negedge clk); kw_valid = 1'b1; kw_in = 32'h01234567;
        @(posedge clk); #1; kw_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (st_out_valid !== 1'b0) $display("FAIL rmid_st_out_valid got %b want 0", st_out_valid); else pass_cnt++;
        total_cnt++; if (st_out !== '0) $display("FAIL rmid_st_out got %h want 0", st_out); else pass_cnt++;
        total_cnt++; if (kw_out_valid !== 1'b0 || kw_out !== '0) $display("FAIL rmid_kw_out got %b/%h want 0/0", kw_out_valid, kw_out); else pass_cnt++;
`ifdef SUBBYTES_SCHED_PERF_EN
        total_cnt++; if (stall_cnt !== 16'd0) $display("FAIL rmid_stall_cnt got %0d want 0", stall_cnt); else pass_cnt++;
`endif
        @(negedge clk); rst_n = 1'b1;
        #1;
        total_cnt++; if (st_ready !== 1'b1) $display("FAIL rmid_st_ready got %b want 1", st_ready); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (st_out_valid !== 1'b0) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL rmid_no_output cycles %0d want 0", bad); else pass_cnt++;
    endtask

    initial begin
        build_table();
        test_reset();
        test_vector();
        test_key_idle();
        test_contention();
        test_simultaneous();
        test_done_hold();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
